aes_key_schedule_seq: RTL and testbench

Sequential AES key-schedule engine covering AES-128, AES-192 and AES-256. It generates one 32-bit expanded-key word per clock into an internal round-key store. The round datapath then reads whole 128-bit round keys by round index, in any order, so forward and inverse cipher share one store. The SubWord S-box sits outside the block on the shared 32-bit `g_in`/`g_out` path, served by the existing `sBox32` in encrypt mode.

---
 rtl/aes_key_schedule_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq
//   Sequential AES-128/192/256 key expansion. One 32-bit expanded-key word is
//   produced per clock into an internal round-key store. Whole 128-bit round
//   keys are then read by round index, in any order and with a 1-cycle latency.
//   SubWord is evaluated outside the block: g_in carries the operand and g_out
//   must return the combinational S-box result within the same cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start                 begin expansion of key_in at key_size (sampled in idle)
//   key_size[1:0]         00 = 128, 01 = 192, 10 = 256, 11 = reserved
//   key_in[255:0]         cipher key, w0 at [255:224]
//   busy, done            expansion in progress / one-cycle completion pulse
//   keys_valid            store holds a complete schedule
//   cfg_err               one-cycle pulse when a start is rejected
//   num_rounds[3:0]       Nr of the stored schedule, 0 when not valid
//   g_in[31:0]            S-box operand (out), g_out[31:0] S-box result (in)
//   rk_rd_en, rk_rd_round round-key read request and round index
//   rk_out, rk_out_valid  round key w[4r]..w[4r+3] (w[4r] at [127:96]), valid flag

module aes_key_schedule_seq #(
  parameter int unsigned MAX_KEY = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         cfg_err,
  output logic [3:0]   num_rounds,
  output logic [31:0]  g_in,
  input  logic [31:0]  g_out,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_round,
  output logic [127:0] rk_out,
  output logic         rk_out_valid
);

  // Store only as deep as the largest key size that can be accepted.
  localparam int unsigned Depth = (MAX_KEY >= 256) ? 60 : ((MAX_KEY >= 192) ? 52 : 44);

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  state_e         r_state;
  state_e         w_state_next;

  logic [1:0]     r_size;
  logic [255:0]   r_key;
  logic [5:0]     r_cnt;
  logic [2:0]     r_mod;
  logic [7:0]     r_rcon;
  logic [31:0]    r_win [8];
  logic [31:0]    r_store [Depth];
  logic           r_keys_valid;
  logic [3:0]     r_num_rounds;
  logic           r_cfg_err;
  logic [127:0]   r_rk_out;
  logic           r_rk_out_valid;

  logic           w_size_ok;
  logic           w_accept;
  logic           w_reject;
  logic [5:0]     w_nk;
  logic [2:0]     w_nk_m1;
  logic [5:0]     w_nwords;
  logic [3:0]     w_nr;
  logic           w_writing;
  logic           w_first;
  logic           w_rot_cyc;
  logic           w_sub_cyc;
  logic [31:0]    w_prev;
  logic [31:0]    w_back;
  logic [31:0]    w_temp;
  logic [31:0]    w_new;
  logic [7:0]     w_rcon_next;
  logic           w_rd_ok;
  logic [5:0]     w_rd_base;

  // ---------------------------------------------------------------------------
  // Start qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    w_size_ok = 1'b0;
    case (key_size)
      2'b00:   w_size_ok = 1'b1;
      2'b01:   w_size_ok = (MAX_KEY >= 32'd192);
      2'b10:   w_size_ok = (MAX_KEY >= 32'd256);
      default: w_size_ok = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-size constants of the captured configuration
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nk     = 6'd4;
    w_nk_m1  = 3'd3;
    w_nwords = 6'd44;
    w_nr     = 4'd10;
    case (r_size)
      2'b01: begin
        w_nk     = 6'd6;
        w_nk_m1  = 3'd5;
        w_nwords = 6'd52;
        w_nr     = 4'd12;
      end
      2'b10: begin
        w_nk     = 6'd8;
        w_nk_m1  = 3'd7;
        w_nwords = 6'd60;
        w_nr     = 4'd14;
      end
      default: begin
        w_nk     = 6'd4;
        w_nk_m1  = 3'd3;
        w_nwords = 6'd44;
        w_nr     = 4'd10;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          if (w_size_ok) begin
            w_accept     = 1'b1;
            w_state_next = StExpand;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      // Counter runs one step past the last word; that extra cycle closes the run.
      StExpand: begin
        if (r_cnt == w_nwords) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word generation datapath
  // ---------------------------------------------------------------------------
  // r_win[0] holds w[i-1], r_win[k] holds w[i-1-k].
  assign w_prev    = r_win[0];
  assign w_writing = (r_state == StExpand) && (r_cnt != w_nwords);
  assign w_first   = (r_cnt < w_nk);
  assign w_rot_cyc = w_writing && !w_first && (r_mod == 3'd0);
  assign w_sub_cyc = w_writing && !w_first && (r_size == 2'b10) && (r_mod == 3'd4);

  always_comb begin
    w_back = r_win[3];
    case (r_size)
      2'b01:   w_back = r_win[5];
      2'b10:   w_back = r_win[7];
      default: w_back = r_win[3];
    endcase
  end

  always_comb begin
    g_in   = 32'h0;
    w_temp = w_prev;
    if (w_rot_cyc) begin
      g_in   = {w_prev[23:0], w_prev[31:24]};
      w_temp = g_out ^ {r_rcon, 24'h0};
    end else if (w_sub_cyc) begin
      g_in   = w_prev;
      w_temp = g_out;
    end
  end

  // Key words are consumed from the top of a shifting copy of the key.
  assign w_new       = w_first ? r_key[255:224] : (w_back ^ w_temp);
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  assign w_rd_ok   = rk_rd_en && r_keys_valid && (r_state != StExpand) &&
                     (rk_rd_round <= r_num_rounds);
  assign w_rd_base = {rk_rd_round, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_size         <= 2'b00;
      r_key          <= 256'h0;
      r_cnt          <= 6'd0;
      r_mod          <= 3'd0;
      r_rcon         <= 8'h01;
      r_keys_valid   <= 1'b0;
      r_num_rounds   <= 4'd0;
      r_cfg_err      <= 1'b0;
      r_rk_out       <= 128'h0;
      r_rk_out_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= w_reject;

      if (w_accept) begin
        r_size       <= key_size;
        r_key        <= key_in;
        r_cnt        <= 6'd0;
        r_mod        <= 3'd0;
        r_rcon       <= 8'h01;
        r_keys_valid <= 1'b0;
        r_num_rounds <= 4'd0;
      end

      if (w_writing) begin
        r_key <= {r_key[223:0], 32'h0};
        r_mod <= (r_mod == w_nk_m1) ? 3'd0 : (r_mod + 3'd1);
        if (w_rot_cyc) begin
          r_rcon <= w_rcon_next;
        end
      end

      if (r_state == StExpand) begin
        r_cnt <= r_cnt + 6'd1;
      end

      if ((r_state == StExpand) && (w_state_next == StDone)) begin
        r_keys_valid <= 1'b1;
        r_num_rounds <= w_nr;
      end

      // A rejected read keeps the last key on rk_out and only drops valid.
      r_rk_out_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rk_out <= {r_store[w_rd_base], r_store[w_rd_base + 6'd1],
                     r_store[w_rd_base + 6'd2], r_store[w_rd_base + 6'd3]};
      end
    end
  end

  // Word store and sliding window carry no reset; keys_valid guards their use.
  always_ff @(posedge clk) begin
    if (rst_n && w_writing) begin
      r_store[r_cnt] <= w_new;
      r_win[0]       <= w_new;
      for (int k = 1; k < 8; k++) begin
        r_win[k] <= r_win[k-1];
      end
    end
  end

  assign busy         = (r_state == StExpand);
  assign done         = (r_state == StDone);
  assign keys_valid   = r_keys_valid;
  assign cfg_err      = r_cfg_err;
  assign num_rounds   = r_num_rounds;
  assign rk_out       = r_rk_out;
  assign rk_out_valid = r_rk_out_valid;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq
//   Self-checking bench for aes_key_schedule_seq. Provides the S-box on the
//   g_in/g_out path (computed from GF(2^8) inverse plus affine map), holds a
//   FIPS-197 style key-expansion model, and compares known-answer vectors,
//   random keys, rejection, bad reads and reset behaviour. A second instance
//   with MAX_KEY = 128 exercises size rejection.

module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         start2;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         busy, done, keys_valid, cfg_err;
  logic [3:0]   num_rounds;
  logic [31:0]  g_in, g_out;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_round;
  logic [127:0] rk_out;
  logic         rk_out_valid;

  logic         busy2, done2, keys_valid2, cfg_err2;
  logic [3:0]   num_rounds2;
  logic [31:0]  g_in2, g_out2;
  logic [127:0] rk_out2;
  logic         rk_out_valid2;

  bit           drive2;
  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  mw [60];
  int           m_nr;
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // S-box from first principles
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign g_out  = sub_word(g_in);
  assign g_out2 = sub_word(g_in2);

  aes_key_schedule_seq #(.MAX_KEY(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid), .cfg_err(cfg_err),
    .num_rounds(num_rounds), .g_in(g_in), .g_out(g_out), .rk_rd_en(rk_rd_en),
    .rk_rd_round(rk_rd_round), .rk_out(rk_out), .rk_out_valid(rk_out_valid)
  );

  aes_key_schedule_seq #(.MAX_KEY(128)) u_dut_128 (
    .clk(clk), .rst_n(rst_n), .start(start2), .key_size(key_size), .key_in(key_in),
    .busy(busy2), .done(done2), .keys_valid(keys_valid2), .cfg_err(cfg_err2),
    .num_rounds(num_rounds2), .g_in(g_in2), .g_out(g_out2), .rk_rd_en(1'b0),
    .rk_rd_round(4'd0), .rk_out(rk_out2), .rk_out_valid(rk_out_valid2)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic model_expand(input logic [1:0] sz, input logic [255:0] key);
    int nk = 4 + 2 * int'(sz);
    int total;
    logic [31:0] t;
    m_nr  = nk + 6;
    total = 4 * (m_nr + 1);
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i / nk - 1], 24'h0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_round(input int r);
    rk_rd_en    = 1'b1;
    rk_rd_round = 4'(r);
    tick();
    rk_rd_en    = 1'b0;
  endtask

  // Run one expansion and verify timing plus every round key (read high to low).
  task automatic run_key(input logic [1:0] sz, input logic [255:0] key, input bit poke);
    int lat = 0;
    int w;
    model_expand(sz, key);
    w        = 4 * (m_nr + 1);
    key_size = sz;
    key_in   = key;
    start    = 1'b1;
    start2   = drive2;
    tick();
    start    = 1'b0;
    start2   = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));
    check("kv_clear_on_start", 256'(keys_valid), 256'(0));
    check("nr_clear_on_start", 256'(num_rounds), 256'(0));
    while (!done && lat < 200) begin
      if (poke && lat == 10) begin
        start       = 1'b1;
        key_in      = ~key;
        rk_rd_en    = 1'b1;
        rk_rd_round = 4'd0;
      end
      tick();
      lat++;
      if (poke && lat == 11) begin
        start    = 1'b0;
        key_in   = key;
        rk_rd_en = 1'b0;
        check("read_busy_valid", 256'(rk_out_valid), 256'(0));
        check("start_busy_no_err", 256'(cfg_err), 256'(0));
        check("start_busy_stays", 256'(busy), 256'(1));
      end
    end
    check("done_latency", 256'(lat), 256'(w + 1));
    check("done_kv", 256'(keys_valid), 256'(1));
    check("done_nr", 256'(num_rounds), 256'(m_nr));
    check("done_not_busy", 256'(busy), 256'(0));
    tick();
    check("done_pulse_drop", 256'(done), 256'(0));
    for (int r = m_nr; r >= 0; r--) begin
      rk_rd_en    = 1'b1;
      rk_rd_round = 4'(r);
      tick();
      check($sformatf("rk_valid_r%0d", r), 256'(rk_out_valid), 256'(1));
      check($sformatf("rk_r%0d", r), 256'(rk_out), 256'(model_rk(r)));
    end
    rk_rd_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [255:0] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] Key192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'h0};
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    start2      = 1'b0;
    key_size    = 2'b00;
    key_in      = '0;
    rk_rd_en    = 1'b0;
    rk_rd_round = 4'd0;
    drive2      = 1'b0;
    repeat (2) tick();
    check("reset_outs",
          256'({busy, done, keys_valid, cfg_err, num_rounds, g_in, rk_out, rk_out_valid}),
          256'(0));
    check("reset_outs_128", 256'({busy2, keys_valid2, cfg_err2, num_rounds2}), 256'(0));
    rst_n = 1'b1;
    tick();

    // AES-128 known answer, also loading the MAX_KEY = 128 instance.
    drive2 = 1'b1;
    run_key(2'b00, Key128, 1'b0);
    drive2 = 1'b0;
    read_round(10);
    check("aes128_r10", 256'(rk_out), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    read_round(0);
    check("aes128_r0", 256'(rk_out), 256'(Key128[255:128]));

    // Round beyond Nr is refused; rk_out keeps round 0.
    read_round(11);
    check("bad_round_valid", 256'(rk_out_valid), 256'(0));
    check("bad_round_hold", 256'(rk_out), 256'(Key128[255:128]));

    // Reserved size rejected, schedule untouched.
    key_size = 2'b11;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("rsv_cfg_err", 256'(cfg_err), 256'(1));
    check("rsv_not_busy", 256'(busy), 256'(0));
    check("rsv_kv_kept", 256'({keys_valid, num_rounds}), 256'({1'b1, 4'd10}));
    tick();
    check("rsv_err_pulse", 256'(cfg_err), 256'(0));
    read_round(10);
    check("rsv_r10_kept", 256'(rk_out), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // AES-256 on a 128-only instance is rejected.
    check("small_kv_before", 256'({keys_valid2, num_rounds2}), 256'({1'b1, 4'd10}));
    key_size = 2'b10;
    start2   = 1'b1;
    tick();
    start2   = 1'b0;
    check("small_cfg_err", 256'(cfg_err2), 256'(1));
    check("small_not_busy", 256'(busy2), 256'(0));
    check("small_kv_kept", 256'({keys_valid2, num_rounds2}), 256'({1'b1, 4'd10}));

    // AES-192 with a start and a read poked mid-run.
    run_key(2'b01, Key192, 1'b1);
    read_round(12);
    check("aes192_r12", 256'(rk_out), 256'(128'he98ba06f448c773c8ecc720401002202));

    // AES-256 known answer.
    run_key(2'b10, Key256, 1'b0);
    read_round(14);
    check("aes256_r14", 256'(rk_out), 256'(128'hfe4890d1e6188d0b046df344706c631e));

    // Random keys and sizes.
    for (int k = 0; k < 6; k++) begin
      logic [255:0] rk;
      for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
      run_key(2'($urandom_range(0, 2)), rk, 1'(k == 2));
    end

    // Reset in the middle of an AES-256 run, then restart with AES-128.
    key_size = 2'b10;
    key_in   = Key256;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (19) tick();
    check("mid_busy", 256'(busy), 256'(1));
    rst_n = 1'b0;
    tick();
    check("mid_reset_outs",
          256'({busy, done, keys_valid, cfg_err, num_rounds, g_in, rk_out, rk_out_valid}),
          256'(0));
    rst_n = 1'b1;
    tick();
    run_key(2'b00, Key128, 1'b0);
    read_round(10);
    check("restart_r10", 256'(rk_out), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
